// File: rtl/cb_pkg.sv
// ----------------------------------------------------------------------------
// cb_pkg
// Shared definitions for the CB BRAM lane mappers: select encodings for the
// DINA/DOUTA lane selects, words fetched per select, and the read-demapper
// FSM state type.
// No ports (package).
// ----------------------------------------------------------------------------
package cb_pkg;

  // Lane-select encodings shared by the write mapper and the read demapper.
  localparam logic [1:0] CB_SEL_IDLE   = 2'b00;
  localparam logic [1:0] CB_SEL_XYXITA = 2'b10;
  localparam logic [1:0] CB_SEL_LXLY   = 2'b11;

  // Words per transaction for each select.
  localparam int unsigned CB_WORDS_XYXITA = 3;
  localparam int unsigned CB_WORDS_LXLY   = 2;

  // Width of the word index k (k = 0..2).
  localparam int unsigned CB_K_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } demap_state_e;

  // True for the two selects that actually fetch data.
  function automatic logic cb_sel_valid(input logic [1:0] sel);
    return (sel == CB_SEL_XYXITA) || (sel == CB_SEL_LXLY);
  endfunction

  // Index of the last word of a transaction (word count minus one).
  function automatic logic [CB_K_W-1:0] cb_last_k(input logic [1:0] sel);
    return (sel == CB_SEL_XYXITA) ? CB_K_W'(CB_WORDS_XYXITA - 1)
                                  : CB_K_W'(CB_WORDS_LXLY - 1);
  endfunction

endpackage

// File: rtl/cb_rd_valid_pipe.sv
// ----------------------------------------------------------------------------
// cb_rd_valid_pipe
// RD_LAT-deep shift register of {valid, k}. Each read issued to the BRAM is
// pushed in on its ena cycle and pops out exactly when the matching douta
// word is on the bus, so the consumer knows which lane to pick.
// Ports:
//   clk       in  clock
//   rst_n     in  asynchronous active-low reset
//   in_valid  in  a read is issued this cycle
//   in_k      in  word index of that read
//   out_valid out douta carries the word tagged out_k this cycle
//   out_k     out word index aligned with douta
// ----------------------------------------------------------------------------
module cb_rd_valid_pipe #(
  parameter int RD_LAT = 2,
  parameter int KW     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [KW-1:0] in_k,
  output logic          out_valid,
  output logic [KW-1:0] out_k
);

  logic [RD_LAT-1:0]         valid_reg;
  logic [RD_LAT-1:0][KW-1:0] k_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      k_reg     <= '0;
    end else begin
      valid_reg[0] <= in_valid;
      k_reg[0]     <= in_k;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        k_reg[i]     <= k_reg[i-1];
      end
    end
  end

  assign out_valid = valid_reg[RD_LAT-1];
  assign out_k     = k_reg[RD_LAT-1];

endmodule

// File: rtl/cb_douta_demap.sv
// ----------------------------------------------------------------------------
// cb_douta_demap
// Read-side counterpart of the CB port-A write lane mapper. Fetches the robot
// pose (x_hat, y_hat, xita_hat; 3 words) or one landmark (lkx, lky; 2 words)
// from CB BRAM port A. Word k carries its value in lane k. The selected output
// group is updated atomically in the single done cycle.
// Ports:
//   clk            in  clock
//   sys_rst_n      in  asynchronous active-low reset (deassertion synchronised)
//   start          in  request pulse, sampled in IDLE only
//   CB_douta_sel   in  2'b10 = XYXITA, 2'b11 = LXLY, others ignored
//   base_addr      in  address of first word
//   CB_ena         out port-A read enable
//   CB_addra       out port-A address (holds last value when idle)
//   CB_douta       in  port-A read data, L lanes of RSA_DW
//   busy           out high from accepted start through the done cycle
//   done           out one-cycle pulse, outputs change in this cycle
//   x_hat, y_hat, xita_hat, lkx, lky  out extracted signed values
//   lane_err       out foreign-lane non-zero seen in last transaction
// Configuration:
//   CB_DEMAP_LANE_CHECK_EN - when defined, every captured word must have all
//   lanes other than its own equal to zero; a violation anywhere in the
//   transaction is reported on lane_err from the done cycle until the next
//   done. When undefined, lane_err is tied to 0.
// ----------------------------------------------------------------------------
module cb_douta_demap
  import cb_pkg::*;
#(
  parameter int L               = 4,
  parameter int RSA_DW          = 32,
  parameter int CB_AW           = 10,
  parameter int CB_DOUTA_SEL_DW = 2,
  parameter int RD_LAT          = 2
) (
  input  logic                       clk,
  input  logic                       sys_rst_n,
  input  logic                       start,
  input  logic [CB_DOUTA_SEL_DW-1:0] CB_douta_sel,
  input  logic [CB_AW-1:0]           base_addr,
  output logic                       CB_ena,
  output logic [CB_AW-1:0]           CB_addra,
  input  logic [L*RSA_DW-1:0]        CB_douta,
  output logic                       busy,
  output logic                       done,
  output logic signed [RSA_DW-1:0]   x_hat,
  output logic signed [RSA_DW-1:0]   y_hat,
  output logic signed [RSA_DW-1:0]   xita_hat,
  output logic signed [RSA_DW-1:0]   lkx,
  output logic signed [RSA_DW-1:0]   lky,
  output logic                       lane_err
);

  localparam int KW = CB_K_W;

  // Reset: asserts immediately, releases on a clock edge.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rst_sync_reg <= 2'b00;
    else            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_n = rst_sync_reg[1];

  demap_state_e               state_reg, state_next;
  logic [CB_DOUTA_SEL_DW-1:0] sel_reg;
  logic [KW-1:0]              last_k_reg;
  logic [KW-1:0]              issue_k_reg;
  logic [CB_AW-1:0]           addr_reg;
  logic                       all_got_reg;
  logic signed [RSA_DW-1:0]   shadow0_reg, shadow1_reg, shadow2_reg;
  logic signed [RSA_DW-1:0]   x_hat_reg, y_hat_reg, xita_hat_reg, lkx_reg, lky_reg;

  logic                       accept;
  logic                       issue_last;
  logic                       load_out;
  logic                       pipe_valid;
  logic [KW-1:0]              pipe_k;
  logic [RSA_DW-1:0]          cap_word;
  logic [L-1:0][RSA_DW-1:0]   lane_w;

  // Split douta into lanes.
  generate
    for (genvar gi = 0; gi < L; gi++) begin : g_lane
      assign lane_w[gi] = CB_douta[gi*RSA_DW +: RSA_DW];
    end
  endgenerate

  assign cap_word   = lane_w[pipe_k];
  assign accept     = (state_reg == ST_IDLE) && start && cb_sel_valid(CB_douta_sel);
  assign issue_last = (issue_k_reg == last_k_reg);
  // Outputs are committed on the edge that enters DONE, so they change
  // together with done rising.
  assign load_out   = (state_reg == ST_DRAIN) && all_got_reg;

  cb_rd_valid_pipe #(
    .RD_LAT (RD_LAT),
    .KW     (KW)
  ) u_valid_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (CB_ena),
    .in_k      (issue_k_reg),
    .out_valid (pipe_valid),
    .out_k     (pipe_k)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (accept)      state_next = ST_ISSUE;
      ST_ISSUE: if (issue_last)  state_next = ST_DRAIN;
      ST_DRAIN: if (all_got_reg) state_next = ST_DONE;
      ST_DONE:                   state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    CB_ena = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (state_reg)
      ST_IDLE:  ;
      ST_ISSUE: begin CB_ena = 1'b1; busy = 1'b1; end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  begin busy = 1'b1; done = 1'b1; end
      default:  ;
    endcase
  end

  // Request latch, address counter and shadow capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg     <= '0;
      last_k_reg  <= '0;
      issue_k_reg <= '0;
      addr_reg    <= '0;
      all_got_reg <= 1'b0;
      shadow0_reg <= '0;
      shadow1_reg <= '0;
      shadow2_reg <= '0;
    end else begin
      if (accept) begin
        sel_reg     <= CB_douta_sel;
        last_k_reg  <= cb_last_k(CB_douta_sel);
        issue_k_reg <= '0;
        addr_reg    <= base_addr;
        all_got_reg <= 1'b0;
      end else if ((state_reg == ST_ISSUE) && !issue_last) begin
        // The address stops on the last issued word so CB_addra holds it.
        issue_k_reg <= issue_k_reg + 1'b1;
        addr_reg    <= addr_reg + 1'b1;
      end

      if (pipe_valid) begin
        if (pipe_k == KW'(0)) shadow0_reg <= cap_word;
        if (pipe_k == KW'(1)) shadow1_reg <= cap_word;
        if (pipe_k == KW'(2)) shadow2_reg <= cap_word;
        if (pipe_k == last_k_reg) all_got_reg <= 1'b1;
      end
    end
  end

  // Output registers: only the selected group moves, and only on load_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_hat_reg    <= '0;
      y_hat_reg    <= '0;
      xita_hat_reg <= '0;
      lkx_reg      <= '0;
      lky_reg      <= '0;
    end else if (load_out) begin
      if (sel_reg == CB_SEL_XYXITA) begin
        x_hat_reg    <= shadow0_reg;
        y_hat_reg    <= shadow1_reg;
        xita_hat_reg <= shadow2_reg;
      end else begin
        lkx_reg      <= shadow0_reg;
        lky_reg      <= shadow1_reg;
      end
    end
  end

  assign CB_addra = addr_reg;
  assign x_hat    = x_hat_reg;
  assign y_hat    = y_hat_reg;
  assign xita_hat = xita_hat_reg;
  assign lkx      = lkx_reg;
  assign lky      = lky_reg;

`ifdef CB_DEMAP_LANE_CHECK_EN
  logic [L-1:0] lane_nz;
  logic [L-1:0] own_mask;
  logic         lane_bad;
  logic         lane_acc_reg;
  logic         lane_err_reg;

  generate
    for (genvar gi = 0; gi < L; gi++) begin : g_lane_nz
      assign lane_nz[gi] = |lane_w[gi];
    end
  endgenerate

  always_comb begin
    own_mask         = '0;
    own_mask[pipe_k] = 1'b1;
  end

  assign lane_bad = pipe_valid && (|(lane_nz & ~own_mask));

  // Sticky per transaction; published on load_out alongside the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_acc_reg <= 1'b0;
      lane_err_reg <= 1'b0;
    end else begin
      if (accept)        lane_acc_reg <= 1'b0;
      else if (lane_bad) lane_acc_reg <= 1'b1;
      if (load_out)      lane_err_reg <= lane_acc_reg;
    end
  end

  assign lane_err = lane_err_reg;
`else
  assign lane_err = 1'b0;
`endif

endmodule

// File: tb/tb_cb_douta_demap.sv
// ----------------------------------------------------------------------------
// tb_cb_douta_demap
// Three demappers share one stimulus: RD_LAT = 2 (main instance 0), 1 and 4.
// Each has its own BRAM read pipeline over a shared memory image.
// ----------------------------------------------------------------------------
module tb_cb_douta_demap;

`ifdef CB_DEMAP_LANE_CHECK_EN
  localparam logic EXP_LE = 1'b1;
`else
  localparam logic EXP_LE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  sel;
  logic [9:0]  base;

  logic               ena_w   [3];
  logic [9:0]         addr_w  [3];
  logic [127:0]       douta_w [3];
  logic               busy_w  [3];
  logic               done_w  [3];
  logic               le_w    [3];
  logic signed [31:0] x_w [3], y_w [3], t_w [3], lkx_w [3], lky_w [3];

  logic [127:0] mem [1024];

  int         cyc = 0;
  int         done_cnt [3] = '{0, 0, 0};
  int         ena_cnt  [3] = '{0, 0, 0};
  logic [9:0] addr_q [$];
  int         lat_of [3] = '{2, 1, 4};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
    logic [127:0] rd_pipe [4];

    always @(posedge clk) begin
      if (ena_w[gi]) rd_pipe[0] <= mem[addr_w[gi]];
      for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign douta_w[gi] = rd_pipe[LAT-1];

    cb_douta_demap #(.RD_LAT(LAT)) u_dut (
      .clk          (clk),
      .sys_rst_n    (rst_n),
      .start        (start),
      .CB_douta_sel (sel),
      .base_addr    (base),
      .CB_ena       (ena_w[gi]),
      .CB_addra     (addr_w[gi]),
      .CB_douta     (douta_w[gi]),
      .busy         (busy_w[gi]),
      .done         (done_w[gi]),
      .x_hat        (x_w[gi]),
      .y_hat        (y_w[gi]),
      .xita_hat     (t_w[gi]),
      .lkx          (lkx_w[gi]),
      .lky          (lky_w[gi]),
      .lane_err     (le_w[gi])
    );
  end

  // Event counters, sampled on the inactive edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
      if (ena_w[i])  ena_cnt[i]  <= ena_cnt[i] + 1;
    end
    if (ena_w[0]) addr_q.push_back(addr_w[0]);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge; t0 is the cycle number of the accepting edge.
  task automatic launch(input logic [1:0] s, input logic [9:0] b, output int t0);
    @(negedge clk);
    sel   = s;
    base  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int t0, qb, d0, e0;
    int lat [3];

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h010] = {32'h0, 32'h0, 32'h0, 32'h0001_0000};
    mem[10'h011] = {32'h0, 32'h0, 32'hFFFF_8000, 32'h0};
    mem[10'h012] = {32'h0, 32'h0000_3244, 32'h0, 32'h0};
    mem[10'h3FF] = {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFB};
    mem[10'h000] = {32'h0, 32'h0, 32'h0000_0007, 32'h0};
    mem[10'h020] = {32'h0000_0001, 32'h0, 32'h0, 32'h0000_0011};
    mem[10'h021] = {32'h0, 32'h0, 32'h0000_0022, 32'h0};

    rst_n = 1'b0;
    start = 1'b0;
    sel   = 2'b00;
    base  = '0;
    idle_cycles(3);

    // Reset state
    check("rst_x_hat",    x_w[0],   32'h0);
    check("rst_xita_hat", t_w[0],   32'h0);
    check("rst_lkx",      lkx_w[0], 32'h0);
    check("rst_busy",     32'(busy_w[0]), 32'h0);
    check("rst_done",     32'(done_w[0]), 32'h0);
    check("rst_ena",      32'(ena_w[0]),  32'h0);
    check("rst_lane_err", 32'(le_w[0]),   32'h0);
    rst_n = 1'b1;
    idle_cycles(4);

    // T1 pose read, with stray starts while busy and in the done cycle.
    qb = addr_q.size();
    d0 = done_cnt[0];
    e0 = ena_cnt[0];
    lat = '{-1, -1, -1};
    launch(2'b10, 10'h010, t0);
    check("t1_busy_after_accept", 32'(busy_w[0]), 32'h1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++)
        if (done_w[i] && lat[i] < 0) lat[i] = cyc - t0;
      start = (cyc == t0 + 1) || done_w[0];
    end
    start = 1'b0;
    idle_cycles(1);
    $display("txn T1 sel=10 base=0x010 x=0x%08h y=0x%08h xita=0x%08h done_lat=%0d",
             x_w[0], y_w[0], t_w[0], lat[0]);
    check("t1_addr0", 32'(addr_q[qb]),   32'h010);
    check("t1_addr1", 32'(addr_q[qb+1]), 32'h011);
    check("t1_addr2", 32'(addr_q[qb+2]), 32'h012);
    check("t1_ena_count",  ena_cnt[0] - e0,  32'd3);
    check("t1_done_count", done_cnt[0] - d0, 32'd1);
    check("t1_busy_end",   32'(busy_w[0]), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_done_latency_lat%0d", lat_of[i]), lat[i], 32'(3 + lat_of[i] + 1));
      check($sformatf("t1_x_lat%0d", lat_of[i]),    x_w[i], 32'h0001_0000);
      check($sformatf("t1_y_lat%0d", lat_of[i]),    y_w[i], 32'hFFFF_8000);
      check($sformatf("t1_xita_lat%0d", lat_of[i]), t_w[i], 32'h0000_3244);
    end
    check("t1_lkx_unchanged", lkx_w[0], 32'h0);
    check("t1_lky_unchanged", lky_w[0], 32'h0);

    // T3b invalid select: no reads, no done.
    d0 = done_cnt[0];
    e0 = ena_cnt[0];
    launch(2'b01, 10'h010, t0);
    check("t3_invalid_busy", 32'(busy_w[0]), 32'h0);
    idle_cycles(12);
    $display("txn T3 sel=01 base=0x010 ena=%0d done=%0d", ena_cnt[0] - e0, done_cnt[0] - d0);
    check("t3_invalid_ena",  ena_cnt[0] - e0,  32'd0);
    check("t3_invalid_done", done_cnt[0] - d0, 32'd0);

    // T2 landmark read with address wrap.
    qb = addr_q.size();
    d0 = done_cnt[0];
    launch(2'b11, 10'h3FF, t0);
    idle_cycles(15);
    $display("txn T2 sel=11 base=0x3ff lkx=0x%08h lky=0x%08h", lkx_w[0], lky_w[0]);
    check("t2_addr0", 32'(addr_q[qb]),   32'h3FF);
    check("t2_addr1", 32'(addr_q[qb+1]), 32'h000);
    check("t2_addra_hold", 32'(addr_w[0]), 32'h000);
    check("t2_done_count", done_cnt[0] - d0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_lkx_lat%0d", lat_of[i]), lkx_w[i], 32'hFFFF_FFFB);
      check($sformatf("t2_lky_lat%0d", lat_of[i]), lky_w[i], 32'h0000_0007);
    end
    check("t2_x_unchanged",    x_w[0], 32'h0001_0000);
    check("t2_xita_unchanged", t_w[0], 32'h0000_3244);

    // T5 dirty foreign lane, then a clean transaction.
    launch(2'b11, 10'h020, t0);
    idle_cycles(15);
    $display("txn T5a sel=11 base=0x020 lkx=0x%08h lane_err=%0b", lkx_w[0], le_w[0]);
    check("t5_lkx",      lkx_w[0], 32'h0000_0011);
    check("t5_lky",      lky_w[0], 32'h0000_0022);
    check("t5_lane_err", 32'(le_w[0]), 32'(EXP_LE));
    launch(2'b11, 10'h3FF, t0);
    idle_cycles(15);
    $display("txn T5b sel=11 base=0x3ff lkx=0x%08h lane_err=%0b", lkx_w[0], le_w[0]);
    check("t5_clean_lane_err", 32'(le_w[0]), 32'h0);
    check("t5_clean_lkx",      lkx_w[0],     32'hFFFF_FFFB);

    // T4 reset while draining.
    d0 = done_cnt[0];
    launch(2'b10, 10'h010, t0);
    idle_cycles(3);
    check("t4_busy_before_reset", 32'(busy_w[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_x",    x_w[0],   32'h0);
    check("t4_rst_lkx",  lkx_w[0], 32'h0);
    check("t4_rst_busy", 32'(busy_w[0]), 32'h0);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(12);
    $display("txn T4 sel=10 base=0x010 reset mid-op done=%0d", done_cnt[0] - d0);
    check("t4_no_done", done_cnt[0] - d0, 32'd0);
    check("t4_x_zero",  x_w[0], 32'h0);

    d0 = done_cnt[0];
    launch(2'b10, 10'h010, t0);
    idle_cycles(15);
    $display("txn T4b sel=10 base=0x010 x=0x%08h y=0x%08h", x_w[0], y_w[0]);
    check("t4b_done_count", done_cnt[0] - d0, 32'd1);
    check("t4b_x",          x_w[0],   32'h0001_0000);
    check("t4b_y",          y_w[0],   32'hFFFF_8000);
    check("t4b_lkx_zero",   lkx_w[0], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
